// File: rtl/beehive_demux_five.sv
// Beehive NoC input port: XY-routes each wormhole packet from one link to one of
// five outputs (0=local, 1=N, 2=E, 3=S, 4=W) through a single-entry output register.
module beehive_demux_five #(
  parameter int WIDTH = 64,
  parameter int XY_W  = 8,
  parameter int LEN_W = 8,
  parameter int MY_X  = 1,
  parameter int MY_Y  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_val,
  input  logic [4:0]       out_rdy,
  output logic [2:0]       out_sel
);

  localparam logic [XY_W-1:0] MYX = XY_W'(MY_X);
  localparam logic [XY_W-1:0] MYY = XY_W'(MY_Y);

  localparam logic [2:0] R_LOCAL = 3'd0;
  localparam logic [2:0] R_NORTH = 3'd1;
  localparam logic [2:0] R_EAST  = 3'd2;
  localparam logic [2:0] R_SOUTH = 3'd3;
  localparam logic [2:0] R_WEST  = 3'd4;

  typedef enum logic {HDR, BODY} state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] body_cnt, cnt_nx;
  logic [2:0]       route_q, route_nx;
  logic [2:0]       hdr_route, flit_route;
  logic             full;
  logic             drain, accept;
  logic [7:0]       rdy_ext;

  logic [XY_W-1:0]  dst_x, dst_y;
  logic [LEN_W-1:0] len;

  assign dst_x = in_data[WIDTH-1 -: XY_W];
  assign dst_y = in_data[WIDTH-1-XY_W -: XY_W];
  assign len   = in_data[WIDTH-1-2*XY_W -: LEN_W];

  // Dimension-order routing: resolve X first, then Y.
  always_comb begin
    hdr_route = R_LOCAL;
    if (dst_x > MYX)      hdr_route = R_EAST;
    else if (dst_x < MYX) hdr_route = R_WEST;
    else if (dst_y > MYY) hdr_route = R_SOUTH;
    else if (dst_y < MYY) hdr_route = R_NORTH;
  end

  // Only the selected output's ready can drain the register.
  assign rdy_ext = {3'b000, out_rdy};
  assign drain   = full && rdy_ext[out_sel];
  assign in_rdy  = !full || drain;
  assign accept  = in_val && in_rdy;

  always_comb begin
    state_nx   = state;
    cnt_nx     = body_cnt;
    route_nx   = route_q;
    flit_route = route_q;
    case (state)
      HDR: begin
        flit_route = hdr_route;
        if (accept) begin
          route_nx = hdr_route;
          if (len != '0) begin
            cnt_nx   = len;
            state_nx = BODY;
          end
        end
      end
      BODY: begin
        if (accept) begin
          cnt_nx = body_cnt - 1'b1;
          if (body_cnt == LEN_W'(1)) state_nx = HDR;
        end
      end
      default: state_nx = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HDR;
      body_cnt <= '0;
      route_q  <= '0;
      full     <= 1'b0;
      out_data <= '0;
      out_sel  <= '0;
    end else begin
      state    <= state_nx;
      body_cnt <= cnt_nx;
      route_q  <= route_nx;
      if (accept) begin
        out_data <= in_data;
        out_sel  <= flit_route;
        full     <= 1'b1;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

  always_comb begin
    out_val = '0;
    if (full) out_val = 5'b00001 << out_sel;
  end

endmodule

// File: tb/tb_beehive_demux_five.sv
// Bench for beehive_demux_five: directed scenarios plus random traffic checked
// against a packet-level reference (per-packet route, one-entry output buffer).
module tb_beehive_demux_five;

  localparam int WIDTH = 64;
  localparam int XY_W  = 8;
  localparam int LEN_W = 8;
  localparam int MY_X  = 1;
  localparam int MY_Y  = 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_val;
  logic             in_rdy;
  logic [WIDTH-1:0] out_data;
  logic [4:0]       out_val;
  logic [4:0]       out_rdy;
  logic [2:0]       out_sel;

  beehive_demux_five #(
    .WIDTH(WIDTH), .XY_W(XY_W), .LEN_W(LEN_W), .MY_X(MY_X), .MY_Y(MY_Y)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy), .out_sel(out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  route;
  } flit_t;

  flit_t       sendq[$];
  logic        m_full;
  logic [63:0] m_data;
  logic [2:0]  m_sel;
  int          vectors;
  int          miscompares;
  int          enq_flits;

  logic [4:0]  obs_val[$];
  logic [2:0]  obs_sel[$];
  logic        obs_rdy[$];
  logic [63:0] obs_data[$];

  function automatic int ref_route(input int dx, input int dy);
    if (dx > MY_X) return 2;
    if (dx < MY_X) return 4;
    if (dy > MY_Y) return 3;
    if (dy < MY_Y) return 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic clear_obs();
    obs_val.delete(); obs_sel.delete(); obs_rdy.delete(); obs_data.delete();
  endtask

  // body_top >= 0 forces the top byte of every body flit (to look like a header).
  task automatic enq_pkt(input int dx, input int dy, input int len, input int body_top);
    flit_t       f;
    logic [63:0] d;
    int          r;
    r = ref_route(dx, dy);
    d = {$urandom, $urandom};
    d[63:56] = dx[7:0];
    d[55:48] = dy[7:0];
    d[47:40] = len[7:0];
    f.data = d; f.route = r[2:0];
    sendq.push_back(f);
    for (int i = 0; i < len; i++) begin
      d = {$urandom, $urandom};
      if (body_top >= 0) begin
        d[63:56] = body_top[7:0];
        d[55:48] = 8'h01;
      end
      f.data = d; f.route = r[2:0];
      sendq.push_back(f);
    end
    enq_flits += len + 1;
  endtask

  // Entered and left at a falling edge; outputs checked against the model before the rising edge.
  task automatic cycle(input bit v, input logic [4:0] rdy);
    logic       exp_rdy, acc, drn;
    logic [4:0] exp_val;
    in_val  = v && (sendq.size() > 0);
    in_data = in_val ? sendq[0].data : {$urandom, $urandom};
    out_rdy = rdy;
    #1;
    exp_rdy = !m_full || rdy[m_sel];
    exp_val = m_full ? (5'b00001 << m_sel) : 5'b00000;
    chk("out_val", 64'(out_val), 64'(exp_val));
    chk("out_sel", 64'(out_sel), 64'(m_sel));
    chk("out_data", out_data, m_data);
    chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
    obs_val.push_back(out_val);
    obs_sel.push_back(out_sel);
    obs_rdy.push_back(in_rdy);
    obs_data.push_back(out_data);
    acc = in_val && exp_rdy;
    drn = m_full && rdy[m_sel];
    @(posedge clk);
    if (acc) begin
      m_data = sendq[0].data;
      m_sel  = sendq[0].route;
      m_full = 1'b1;
      void'(sendq.pop_front());
    end else if (drn) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic flush();
    int n;
    n = 0;
    while ((sendq.size() > 0 || m_full) && n < 3000) begin
      cycle(1'b1, 5'b11111);
      n++;
    end
    if (n >= 3000) chk("flush_timeout", 64'(n), 64'(0));
  endtask

  task automatic do_reset();
    in_val = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_out_sel", 64'(out_sel), 64'(0));
    chk("rst_in_rdy", 64'(in_rdy), 64'(1));
    m_full = 1'b0; m_data = '0; m_sel = '0;
    sendq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int          exp_s[5];
    int          n, cyc;
    logic [63:0] held;
    vectors = 0; miscompares = 0; enq_flits = 0;
    m_full = 1'b0; m_data = '0; m_sel = '0;
    in_val = 1'b0; in_data = '0; out_rdy = '0; rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Back-to-back headers to every output.
    clear_obs();
    enq_pkt(3, 1, 0, -1); enq_pkt(0, 1, 0, -1); enq_pkt(1, 3, 0, -1);
    enq_pkt(1, 0, 0, -1); enq_pkt(1, 1, 0, -1);
    exp_s = '{2, 4, 3, 1, 0};
    repeat (6) cycle(1'b1, 5'b11111);
    for (int i = 0; i < 5; i++) begin
      chk("hdr_sel", 64'(obs_sel[i+1]), 64'(exp_s[i]));
      chk("hdr_val", 64'(obs_val[i+1]), 64'(5'b00001 << exp_s[i]));
    end

    // Body flits that look like west-bound headers must follow the east header.
    clear_obs();
    enq_pkt(3, 1, 3, 0);
    flush();
    n = 0;
    foreach (obs_val[i]) if (obs_val[i] != 5'b0) begin
      chk("body_val", 64'(obs_val[i]), 64'(5'b00100));
      n++;
    end
    chk("body_count", 64'(n), 64'(4));
    clear_obs();
    enq_pkt(1, 1, 0, -1);
    flush();
    chk("after_body_local", 64'(obs_val[1]), 64'(5'b00001));

    // Backpressure on E while a second flit waits.
    clear_obs();
    enq_pkt(3, 1, 0, -1);
    held = sendq[0].data;
    enq_pkt(1, 1, 0, -1);
    cycle(1'b1, 5'b11111);
    repeat (4) cycle(1'b1, 5'b11011);
    cycle(1'b1, 5'b00100);
    cycle(1'b1, 5'b00100);
    for (int i = 1; i <= 4; i++) begin
      chk("stall_in_rdy", 64'(obs_rdy[i]), 64'(0));
      chk("stall_data", obs_data[i], held);
    end
    chk("drain_in_rdy", 64'(obs_rdy[5]), 64'(1));
    chk("next_sel", 64'(obs_sel[6]), 64'(0));
    flush();

    // Packet boundary with no bubble.
    clear_obs();
    enq_pkt(3, 1, 1, -1);
    enq_pkt(1, 1, 0, -1);
    repeat (4) cycle(1'b1, 5'b11111);
    exp_s = '{2, 2, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      chk("b2b_sel", 64'(obs_sel[i+1]), 64'(exp_s[i]));
      chk("b2b_val", 64'(obs_val[i+1]), 64'(5'b00001 << exp_s[i]));
    end

    // Reset inside a west-bound packet, after two body flits.
    enq_pkt(0, 1, 5, -1);
    while (sendq.size() > 3) void'(sendq.pop_back());
    repeat (3) cycle(1'b1, 5'b11111);
    cycle(1'b0, 5'b11111);
    do_reset();
    clear_obs();
    enq_pkt(2, 1, 0, -1);
    repeat (2) cycle(1'b1, 5'b11111);
    chk("post_rst_sel", 64'(obs_sel[1]), 64'(2));
    chk("post_rst_val", 64'(obs_val[1]), 64'(5'b00100));

    // Random traffic, including one maximum-length packet.
    enq_flits = 0;
    enq_pkt(3, 2, 255, -1);
    cyc = 0;
    while (enq_flits < 10000 && cyc < 80000) begin
      if (sendq.size() < 2) begin
        int dx, dy;
        dx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
        dy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
        enq_pkt(dx, dy, $urandom_range(0, 6), -1);
      end
      cycle($urandom_range(0, 3) != 0,
            {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
      cyc++;
    end
    if (cyc >= 80000) chk("random_timeout", 64'(cyc), 64'(0));
    flush();
    cycle(1'b0, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
